xcvr_reset_seq: RTL and testbench

Parametrised multi-channel transceiver reset sequencer. It sits between the board-level reset and NUM_CH PHY IP channels, and drives per-channel analog and digital resets for TX and RX in the vendor-mandated order. Each channel has independent TX and RX state machines, a per-channel software reset request, and optional RX lock-loss recovery with event counting.

---
 rtl/xcvr_reset_seq.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_xcvr_reset_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcvr_reset_seq.sv
// ---------------------------------------------------------------------------
// xcvr_reset_seq
//
// Multi-channel transceiver reset sequencer. For every channel an independent
// TX and RX state machine walk ANA -> DIG -> RDYW -> RDY, driving the PHY
// analog reset, digital reset and ready flags in the order the PHY requires.
//
// Optional feature macro: XCVR_RESET_LOCK_MON_EN
//   defined   : RX lock monitor. A run of LOCK_LOSS_CYCLES consecutive
//               unlocked cycles in R_DIG/R_RDYW/R_RDY sends RX back to R_DIG
//               and bumps a per-channel saturating 8-bit lock-loss counter.
//   undefined : lock only gates R_DIG counting and lock_loss_count reads 0.
//
// All outputs are registered. Next values are computed from the next state,
// so outputs change on the same edge as the state transition.
// ---------------------------------------------------------------------------
module xcvr_reset_seq #(
    parameter int NUM_CH           = 1,
    parameter int CNT_W            = 16,
    parameter int ANALOG_CYCLES    = 4,
    parameter int TX_DIG_CYCLES    = 625,
    parameter int RX_DIG_CYCLES    = 500,
    parameter int READY_CYCLES     = 10,
    parameter int LOCK_LOSS_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     ch_reset_req,
    input  logic [NUM_CH-1:0]     tx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_cal_busy,
    input  logic [NUM_CH-1:0]     rx_is_lockedtodata,
    output logic [NUM_CH-1:0]     tx_analogreset,
    output logic [NUM_CH-1:0]     tx_digitalreset,
    output logic [NUM_CH-1:0]     tx_ready,
    output logic [NUM_CH-1:0]     rx_analogreset,
    output logic [NUM_CH-1:0]     rx_digitalreset,
    output logic [NUM_CH-1:0]     rx_ready,
    output logic [8*NUM_CH-1:0]   lock_loss_count
);

    typedef enum logic [1:0] {
        T_ANA  = 2'd0,
        T_DIG  = 2'd1,
        T_RDYW = 2'd2,
        T_RDY  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        R_ANA  = 2'd0,
        R_DIG  = 2'd1,
        R_RDYW = 2'd2,
        R_RDY  = 2'd3
    } rx_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // A duration of zero behaves like a duration of one cycle.
    function automatic logic [CNT_W-1:0] load_val(input int n);
        logic [CNT_W-1:0] v;
        if (n <= 0) begin
            v = CNT_ONE;
        end else begin
            v = n[CNT_W-1:0];
        end
        return v;
    endfunction

    localparam logic [CNT_W-1:0] ANA_LOAD = load_val(ANALOG_CYCLES);
    localparam logic [CNT_W-1:0] TXD_LOAD = load_val(TX_DIG_CYCLES);
    localparam logic [CNT_W-1:0] RXD_LOAD = load_val(RX_DIG_CYCLES);
    localparam logic [CNT_W-1:0] RDY_LOAD = load_val(READY_CYCLES);
`ifdef XCVR_RESET_LOCK_MON_EN
    localparam logic [CNT_W-1:0] LL_LOAD  = load_val(LOCK_LOSS_CYCLES);
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

        // ------------------------------------------------------------------
        // TX sequencer
        // ------------------------------------------------------------------
        tx_state_e        tx_state_q, tx_state_d;
        logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
        logic             tx_ana_q, tx_ana_d;
        logic             tx_dig_q, tx_dig_d;
        logic             tx_rdy_q, tx_rdy_d;

        // TX next state: the counter reloads on entry and the state is left
        // on the enabled cycle that finds the counter at one.
        always_comb begin
            tx_state_d = tx_state_q;
            tx_cnt_d   = tx_cnt_q;
            if (ch_reset_req[g]) begin
                tx_state_d = T_ANA;
                tx_cnt_d   = ANA_LOAD;
            end else begin
                case (tx_state_q)
                    T_ANA: begin
                        if (tx_cnt_q == CNT_ONE) begin
                            tx_state_d = T_DIG;
                            tx_cnt_d   = TXD_LOAD;
                        end else begin
                            tx_cnt_d   = tx_cnt_q - CNT_ONE;
                        end
                    end
                    T_DIG: begin
                        if (tx_cal_busy[g]) begin
                            tx_cnt_d   = tx_cnt_q;
                        end else if (tx_cnt_q == CNT_ONE) begin
                            tx_state_d = T_RDYW;
                            tx_cnt_d   = RDY_LOAD;
                        end else begin
                            tx_cnt_d   = tx_cnt_q - CNT_ONE;
                        end
                    end
                    T_RDYW: begin
                        if (tx_cnt_q == CNT_ONE) begin
                            tx_state_d = T_RDY;
                            tx_cnt_d   = CNT_ONE;
                        end else begin
                            tx_cnt_d   = tx_cnt_q - CNT_ONE;
                        end
                    end
                    T_RDY: begin
                        tx_state_d = T_RDY;
                    end
                    default: begin
                        tx_state_d = T_ANA;
                        tx_cnt_d   = ANA_LOAD;
                    end
                endcase
            end
            tx_ana_d = (tx_state_d == T_ANA);
            tx_dig_d = (tx_state_d == T_ANA) || (tx_state_d == T_DIG);
            tx_rdy_d = (tx_state_d == T_RDY);
        end

        // TX state, counter and registered outputs.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                tx_state_q <= T_ANA;
                tx_cnt_q   <= ANA_LOAD;
                tx_ana_q   <= 1'b1;
                tx_dig_q   <= 1'b1;
                tx_rdy_q   <= 1'b0;
            end else begin
                tx_state_q <= tx_state_d;
                tx_cnt_q   <= tx_cnt_d;
                tx_ana_q   <= tx_ana_d;
                tx_dig_q   <= tx_dig_d;
                tx_rdy_q   <= tx_rdy_d;
            end
        end

        // ------------------------------------------------------------------
        // RX sequencer
        // ------------------------------------------------------------------
        rx_state_e        rx_state_q, rx_state_d;
        logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
        logic             rx_ana_q, rx_ana_d;
        logic             rx_dig_q, rx_dig_d;
        logic             rx_rdy_q, rx_rdy_d;
        logic             rx_en_s;
`ifdef XCVR_RESET_LOCK_MON_EN
        logic [CNT_W-1:0] run_q, run_d;
        logic [7:0]       llc_q, llc_d;
        logic             mon_s;
        logic             loss_s;
`endif

        // RX next state. Priority: channel request, lock loss (when the
        // monitor is built in), then normal counting. R_DIG only counts while
        // calibration is idle and the CDR is locked to data.
        always_comb begin
            rx_state_d = rx_state_q;
            rx_cnt_d   = rx_cnt_q;
            rx_en_s    = ~rx_cal_busy[g] & rx_is_lockedtodata[g];
`ifdef XCVR_RESET_LOCK_MON_EN
            run_d      = run_q;
            llc_d      = llc_q;
            mon_s      = (rx_state_q != R_ANA);
            loss_s     = mon_s & ~rx_is_lockedtodata[g] & (run_q == (LL_LOAD - CNT_ONE));
`endif
            if (ch_reset_req[g]) begin
                rx_state_d = R_ANA;
                rx_cnt_d   = ANA_LOAD;
            end
`ifdef XCVR_RESET_LOCK_MON_EN
            else if (loss_s) begin
                rx_state_d = R_DIG;
                rx_cnt_d   = RXD_LOAD;
                llc_d      = (llc_q == 8'hFF) ? llc_q : (llc_q + 8'd1);
            end
`endif
            else begin
                case (rx_state_q)
                    R_ANA: begin
                        if (rx_cnt_q == CNT_ONE) begin
                            rx_state_d = R_DIG;
                            rx_cnt_d   = RXD_LOAD;
                        end else begin
                            rx_cnt_d   = rx_cnt_q - CNT_ONE;
                        end
                    end
                    R_DIG: begin
                        if (!rx_en_s) begin
                            rx_cnt_d   = rx_cnt_q;
                        end else if (rx_cnt_q == CNT_ONE) begin
                            rx_state_d = R_RDYW;
                            rx_cnt_d   = RDY_LOAD;
                        end else begin
                            rx_cnt_d   = rx_cnt_q - CNT_ONE;
                        end
                    end
                    R_RDYW: begin
                        if (rx_cnt_q == CNT_ONE) begin
                            rx_state_d = R_RDY;
                            rx_cnt_d   = CNT_ONE;
                        end else begin
                            rx_cnt_d   = rx_cnt_q - CNT_ONE;
                        end
                    end
                    R_RDY: begin
                        rx_state_d = R_RDY;
                    end
                    default: begin
                        rx_state_d = R_ANA;
                        rx_cnt_d   = ANA_LOAD;
                    end
                endcase
            end
`ifdef XCVR_RESET_LOCK_MON_EN
            // The unlocked-run counter restarts on lock, on any state change
            // (a lock-loss re-entry of R_DIG included) and outside the
            // monitored states.
            if (ch_reset_req[g] || loss_s || (rx_state_d != rx_state_q) ||
                rx_is_lockedtodata[g] || !mon_s) begin
                run_d = CNT_ZERO;
            end else begin
                run_d = run_q + CNT_ONE;
            end
`endif
            rx_ana_d = (rx_state_d == R_ANA);
            rx_dig_d = (rx_state_d == R_ANA) || (rx_state_d == R_DIG);
            rx_rdy_d = (rx_state_d == R_RDY);
        end

        // RX state, counter and registered outputs.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rx_state_q <= R_ANA;
                rx_cnt_q   <= ANA_LOAD;
                rx_ana_q   <= 1'b1;
                rx_dig_q   <= 1'b1;
                rx_rdy_q   <= 1'b0;
            end else begin
                rx_state_q <= rx_state_d;
                rx_cnt_q   <= rx_cnt_d;
                rx_ana_q   <= rx_ana_d;
                rx_dig_q   <= rx_dig_d;
                rx_rdy_q   <= rx_rdy_d;
            end
        end

`ifdef XCVR_RESET_LOCK_MON_EN
        // Lock-loss run length and event counter; only reset_n clears the
        // event counter, a channel request leaves it untouched.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                run_q <= CNT_ZERO;
                llc_q <= 8'd0;
            end else begin
                run_q <= run_d;
                llc_q <= llc_d;
            end
        end

        assign lock_loss_count[8*g +: 8] = llc_q;
`else
        assign lock_loss_count[8*g +: 8] = 8'd0;
`endif

        assign tx_analogreset[g]  = tx_ana_q;
        assign tx_digitalreset[g] = tx_dig_q;
        assign tx_ready[g]        = tx_rdy_q;
        assign rx_analogreset[g]  = rx_ana_q;
        assign rx_digitalreset[g] = rx_dig_q;
        assign rx_ready[g]        = rx_rdy_q;
    end

endmodule

// File: tb/tb_xcvr_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_xcvr_reset_seq
//
// Directed and randomized bench for xcvr_reset_seq (2 channels, short
// durations). The reference model tracks, per channel and direction, the
// number of enabled cycles completed since the sequence started; every
// output is a threshold on that progress count.
// Honours XCVR_RESET_LOCK_MON_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_xcvr_reset_seq;

    localparam int NCH = 2;
    localparam int A   = 2;
    localparam int TD  = 8;
    localparam int RD  = 6;
    localparam int RY  = 3;
    localparam int LL  = 4;
    localparam int HN  = 40;

`ifdef XCVR_RESET_LOCK_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic [NCH-1:0]     ch_reset_req = '0;
    logic [NCH-1:0]     tx_cal_busy = '0;
    logic [NCH-1:0]     rx_cal_busy = '0;
    logic [NCH-1:0]     rx_is_lockedtodata = '1;
    logic [NCH-1:0]     tx_analogreset, tx_digitalreset, tx_ready;
    logic [NCH-1:0]     rx_analogreset, rx_digitalreset, rx_ready;
    logic [8*NCH-1:0]   lock_loss_count;

    xcvr_reset_seq #(
        .NUM_CH(NCH), .CNT_W(16), .ANALOG_CYCLES(A), .TX_DIG_CYCLES(TD),
        .RX_DIG_CYCLES(RD), .READY_CYCLES(RY), .LOCK_LOSS_CYCLES(LL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch_reset_req(ch_reset_req),
        .tx_cal_busy(tx_cal_busy), .rx_cal_busy(rx_cal_busy),
        .rx_is_lockedtodata(rx_is_lockedtodata),
        .tx_analogreset(tx_analogreset), .tx_digitalreset(tx_digitalreset),
        .tx_ready(tx_ready), .rx_analogreset(rx_analogreset),
        .rx_digitalreset(rx_digitalreset), .rx_ready(rx_ready),
        .lock_loss_count(lock_loss_count)
    );

    always #4 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_tx [NCH];
    int m_rx [NCH];
    int m_run[NCH];
    int m_llc[NCH];

    int         ecount = 0;
    logic [5:0] hist[NCH][HN+1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rx_phase(input int p);
        if (p < A) return 0;
        else if (p < A + RD) return 1;
        else if (p < A + RD + RY) return 2;
        else return 3;
    endfunction

    // {tx_ana, tx_dig, tx_rdy, rx_ana, rx_dig, rx_rdy}
    function automatic logic [5:0] exp_ch(input int c);
        return {m_tx[c] < A, m_tx[c] < A + TD, m_tx[c] >= A + TD + RY,
                m_rx[c] < A, m_rx[c] < A + RD, m_rx[c] >= A + RD + RY};
    endfunction

    function automatic logic [5:0] got_ch(input int c);
        return {tx_analogreset[c], tx_digitalreset[c], tx_ready[c],
                rx_analogreset[c], rx_digitalreset[c], rx_ready[c]};
    endfunction

    function automatic logic [15:0] exp_llc();
        logic [15:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[8*c +: 8] = 8'(m_llc[c]);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_tx[c] = 0; m_rx[c] = 0; m_run[c] = 0; m_llc[c] = 0;
        end
    endtask

    // One clock edge of the specification's behaviour, from current inputs.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int oldph;
            bit lk;
            lk = rx_is_lockedtodata[c];
            if (ch_reset_req[c]) m_tx[c] = 0;
            else if (m_tx[c] < A + TD + RY) begin
                if (!(m_tx[c] >= A && m_tx[c] < A + TD && tx_cal_busy[c])) m_tx[c]++;
            end
            oldph = rx_phase(m_rx[c]);
            if (ch_reset_req[c]) begin
                m_rx[c] = 0; m_run[c] = 0;
            end else if (MON && oldph != 0 && !lk && m_run[c] == LL - 1) begin
                m_rx[c] = A; m_run[c] = 0;
                if (m_llc[c] < 255) m_llc[c]++;
            end else begin
                if (m_rx[c] < A + RD + RY && !(oldph == 1 && (rx_cal_busy[c] || !lk))) m_rx[c]++;
                if (!MON || lk || oldph == 0 || rx_phase(m_rx[c]) != oldph) m_run[c] = 0;
                else m_run[c]++;
            end
        end
    endtask

    task automatic clear_hist();
        ecount = 0;
        for (int c = 0; c < NCH; c++)
            for (int e = 0; e <= HN; e++) hist[c][e] = 6'bxxxxxx;
    endtask

    // Advance one edge, update the model, compare #1 later, drop any request.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        ecount++;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("outs_ch%0d_e%0d", c, ecount), 32'(got_ch(c)), 32'(exp_ch(c)));
            if (ecount <= HN) hist[c][ecount] = got_ch(c);
        end
        chk($sformatf("llc_e%0d", ecount), 32'(lock_loss_count), 32'(exp_llc()));
        ch_reset_req = '0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int first_edge(input int c, input int b, input logic v);
        for (int e = 1; e <= HN; e++) if (hist[c][e][b] === v) return e;
        return -1;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_ana"}, 32'(tx_analogreset),  32'(2'b11));
        chk({tag, "_tx_dig"}, 32'(tx_digitalreset), 32'(2'b11));
        chk({tag, "_tx_rdy"}, 32'(tx_ready),        32'(2'b00));
        chk({tag, "_rx_ana"}, 32'(rx_analogreset),  32'(2'b11));
        chk({tag, "_rx_dig"}, 32'(rx_digitalreset), 32'(2'b11));
        chk({tag, "_rx_rdy"}, 32'(rx_ready),        32'(2'b00));
        chk({tag, "_llc"},    32'(lock_loss_count), 32'(16'h0000));
    endtask

    // Asynchronous reset assert, check, and release so the next edge is E1.
    task automatic apply_reset(input string tag);
        #2 reset_n = 1'b0;
        model_reset();
        #1 chk_reset_vals(tag);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_hist();
    endtask

    task automatic chk_timing(input string tag, input int c, input int ana,
                              input int txd, input int txr, input int rxd, input int rxr);
        chk($sformatf("%s_ch%0d_tx_ana_fall", tag, c), 32'(first_edge(c, 5, 1'b0)), 32'(ana));
        chk($sformatf("%s_ch%0d_tx_dig_fall", tag, c), 32'(first_edge(c, 4, 1'b0)), 32'(txd));
        chk($sformatf("%s_ch%0d_tx_rdy_rise", tag, c), 32'(first_edge(c, 3, 1'b1)), 32'(txr));
        chk($sformatf("%s_ch%0d_rx_ana_fall", tag, c), 32'(first_edge(c, 2, 1'b0)), 32'(ana));
        chk($sformatf("%s_ch%0d_rx_dig_fall", tag, c), 32'(first_edge(c, 1, 1'b0)), 32'(rxd));
        chk($sformatf("%s_ch%0d_rx_rdy_rise", tag, c), 32'(first_edge(c, 0, 1'b1)), 32'(rxr));
    endtask

    initial begin
        // Power-on reset and plain sequence on both channels.
        apply_reset("por");
        steps(20);
        chk_timing("plain", 0, 2, 10, 13, 8, 11);
        chk_timing("plain", 1, 2, 10, 13, 8, 11);

        // TX busy on ch0 for 5 DIG cycles, RX unlock on ch1 for 3 DIG cycles.
        apply_reset("rst2");
        steps(3);
        tx_cal_busy[0]        = 1'b1;
        rx_is_lockedtodata[1] = 1'b0;
        steps(3);
        rx_is_lockedtodata[1] = 1'b1;
        steps(2);
        tx_cal_busy[0]        = 1'b0;
        steps(17);
        chk_timing("busy", 0, 2, 15, 18, 8, 11);
        chk_timing("lock", 1, 2, 10, 13, 11, 14);
        chk("lock_llc_zero", 32'(lock_loss_count), 32'(16'h0000));

        // Short dropout in R_RDY: no effect.
        rx_is_lockedtodata[0] = 1'b0;
        steps(3);
        rx_is_lockedtodata[0] = 1'b1;
        steps(1);
        chk("short_drop_rdy", 32'(rx_ready[0]), 32'(1'b1));

        // Full lock loss in R_RDY, then relock.
        rx_is_lockedtodata[0] = 1'b0;
        steps(4);
        chk("loss_rx_rdy", 32'(rx_ready[0]),        32'(MON ? 1'b0 : 1'b1));
        chk("loss_rx_dig", 32'(rx_digitalreset[0]), 32'(MON ? 1'b1 : 1'b0));
        chk("loss_count",  32'(lock_loss_count[7:0]), 32'(MON ? 8'd1 : 8'd0));
        rx_is_lockedtodata[0] = 1'b1;
        steps(8);
        chk("relock_not_yet", 32'(rx_ready[0]), 32'(MON ? 1'b0 : 1'b1));
        steps(1);
        chk("relock_ready", 32'(rx_ready[0]), 32'(1'b1));

        // Channel request on ch1 in steady state.
        ch_reset_req = 2'b10;
        step();
        chk("req_ch1_outs", 32'(got_ch(1)), 32'(6'b110110));
        chk("req_ch0_kept", 32'(got_ch(0)), 32'(6'b001001));
        clear_hist();
        steps(20);
        chk_timing("req", 1, 2, 10, 13, 8, 11);

        // Request coincident with a lock-loss edge on ch0.
        rx_is_lockedtodata[0] = 1'b0;
        steps(3);
        ch_reset_req = 2'b01;
        step();
        chk("req_vs_loss_count", 32'(lock_loss_count[7:0]), 32'(MON ? 8'd1 : 8'd0));
        chk("req_vs_loss_outs",  32'(got_ch(0)), 32'(6'b110110));
        rx_is_lockedtodata[0] = 1'b1;
        steps(5);

        // Lock held low long enough for 300+ loss events.
        rx_is_lockedtodata[0] = 1'b0;
        steps(1300);
        chk("llc_saturate", 32'(lock_loss_count[7:0]), 32'(MON ? 8'd255 : 8'd0));
        rx_is_lockedtodata[0] = 1'b1;
        steps(20);

        // Randomized phase against the model.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NCH; c++) begin
                tx_cal_busy[c] = ($urandom_range(3) == 0);
                rx_cal_busy[c] = ($urandom_range(3) == 0);
                if ($urandom_range(7) == 0) rx_is_lockedtodata[c] = ~rx_is_lockedtodata[c];
                ch_reset_req[c] = ($urandom_range(63) == 0);
            end
            step();
        end
        tx_cal_busy = '0;
        rx_cal_busy = '0;
        rx_is_lockedtodata = '1;
        steps(30);

        // Asynchronous reset in the middle of T_DIG.
        apply_reset("rst3");
        steps(4);
        #2 reset_n = 1'b0;
        model_reset();
        #1 chk_reset_vals("mid_dig");
        @(negedge clk);
        reset_n = 1'b1;
        clear_hist();
        steps(15);
        chk_timing("after_mid", 0, 2, 10, 13, 8, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
